// File: rtl/pipe_reg_elastic.sv
// pipe_reg_elastic: a valid/ready pipeline of Depth register stages.
// Every stage carries its own valid bit, and the stage-ready chain runs
// combinationally from the output back to the input. An empty stage
// therefore always accepts a word, bubbles collapse, and backpressure
// stalls only the stages that are occupied.
// Depth = 0 turns the block into a combinational pass-through.
// Optional feature macro: PIPE_REG_ELASTIC_ZERO_DATA_EN. When it is
// defined, the data registers reset and clear to zero so that data_o is
// '0 whenever valid_o is low.
module pipe_reg_elastic #(
  parameter type         dtype    = logic,
  parameter int unsigned Depth    = 2,
  localparam int unsigned CntWidth = (Depth == 0) ? 1 : $clog2(Depth + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  dtype                data_i,
  output logic                valid_o,
  input  logic                ready_i,
  output dtype                data_o,
  output logic [CntWidth-1:0] fill_o
);

  generate
    if (Depth == 0) begin : g_pass
      // There is no state. The handshake passes straight through, and flush_i is ignored.
      assign valid_o = valid_i;
      assign data_o  = data_i;
      assign ready_o = ready_i;
      assign fill_o  = '0;
    end else begin : g_pipe
      logic [Depth-1:0]    v_q;
      dtype                d_q  [Depth];
      logic [Depth-1:0]    rdy;
      logic [Depth-1:0]    v_in;
      dtype                d_in [Depth];
      logic [CntWidth-1:0] fill_cnt;

      for (genvar gi = 0; gi < Depth; gi++) begin : g_stage
        // Stage 0 is fed by the upstream port. Every later stage is fed by its predecessor.
        if (gi == 0) begin : g_src_in
          assign v_in[gi] = valid_i;
          assign d_in[gi] = data_i;
        end else begin : g_src_prev
          assign v_in[gi] = v_q[gi-1];
          assign d_in[gi] = d_q[gi-1];
        end

        // A stage may advance when it is empty or when the stage ahead can take its word.
        if (gi == Depth - 1) begin : g_rdy_last
          assign rdy[gi] = ~v_q[gi] | ready_i;
        end else begin : g_rdy_mid
          assign rdy[gi] = ~v_q[gi] | rdy[gi+1];
        end

        // Valid bit: reset and flush empty the stage; otherwise it advances when ready.
        always_ff @(posedge clk_i) begin
          if (rst_i) begin
            v_q[gi] <= 1'b0;
          end else if (flush_i) begin
            v_q[gi] <= 1'b0;
          end else if (rdy[gi]) begin
            v_q[gi] <= v_in[gi];
          end
        end

`ifdef PIPE_REG_ELASTIC_ZERO_DATA_EN
        // Payload is zeroed whenever its stage ends up empty, so data_o is clean while idle.
        always_ff @(posedge clk_i) begin
          if (rst_i || flush_i) begin
            d_q[gi] <= '0;
          end else if (rdy[gi]) begin
            d_q[gi] <= v_in[gi] ? d_in[gi] : '0;
          end
        end
`else
        // Payload loads only when a valid word moves into this stage; it is not reset.
        always_ff @(posedge clk_i) begin
          if (rdy[gi] && v_in[gi]) begin
            d_q[gi] <= d_in[gi];
          end
        end
`endif
      end

      // The occupancy count is the number of stages holding a valid word.
      always_comb begin
        fill_cnt = '0;
        for (int i = 0; i < Depth; i++) begin
          fill_cnt = fill_cnt + CntWidth'(v_q[i]);
        end
      end

      assign ready_o = rdy[0] & ~flush_i;
      assign valid_o = v_q[Depth-1];
      assign data_o  = d_q[Depth-1];
      assign fill_o  = fill_cnt;
    end
  endgenerate

endmodule
